// File: rtl/program_loader_if.sv
// Stream-in, memory write and run-control signals between the external loader,
// program_loader and the processor. The loader block sits on the slave side.
interface program_loader_if #(
    parameter int IMEM_DEPTH = 64,
    parameter int DMEM_DEPTH = 64,
    parameter int WORD_W     = 32
);
    localparam int IA = $clog2(IMEM_DEPTH);
    localparam int DA = $clog2(DMEM_DEPTH);

    logic              in_valid;
    logic              in_ready;
    logic [WORD_W-1:0] in_word;
    logic              in_last;
    logic              imem_we;
    logic [IA-1:0]     imem_addr;
    logic [WORD_W-1:0] imem_wdata;
    logic              dmem_we;
    logic [DA-1:0]     dmem_addr;
    logic [WORD_W-1:0] dmem_wdata;
    logic              start_signal;
    logic              end_signal;

    modport slave (
        input  in_valid, in_word, in_last, end_signal,
        output in_ready, imem_we, imem_addr, imem_wdata,
        output dmem_we, dmem_addr, dmem_wdata, start_signal
    );

    modport master (
        output in_valid, in_word, in_last, end_signal,
        input  in_ready, imem_we, imem_addr, imem_wdata,
        input  dmem_we, dmem_addr, dmem_wdata, start_signal
    );
endinterface

// File: rtl/program_loader.sv
// Load-then-run sequencer: streams the instruction segment into imem, the data
// segment into dmem, then holds start_signal until the processor reports end.
module program_loader #(
    parameter int IMEM_DEPTH = 64,
    parameter int DMEM_DEPTH = 64,
    parameter int WORD_W     = 32,
    localparam int IA = $clog2(IMEM_DEPTH),
    localparam int DA = $clog2(DMEM_DEPTH)
) (
    input  logic              clk,
    input  logic              reset,
    program_loader_if.slave   bus,
    output logic [IA:0]       instr_count,
    output logic [DA:0]       data_count,
    output logic              overflow_err,
    output logic              done
);
    localparam logic [1:0] S_LOAD_I = 2'd0;
    localparam logic [1:0] S_LOAD_D = 2'd1;
    localparam logic [1:0] S_RUN    = 2'd2;
    localparam logic [1:0] S_DONE   = 2'd3;

    localparam logic [IA:0] I_FULL = (IA+1)'(IMEM_DEPTH);
    localparam logic [DA:0] D_FULL = (DA+1)'(DMEM_DEPTH);

    logic [1:0]        state_reg, state_next;
    logic [IA:0]       instr_count_reg;
    logic [DA:0]       data_count_reg;
    logic              overflow_reg;
    logic              imem_we_reg, dmem_we_reg;
    logic [IA-1:0]     imem_addr_reg;
    logic [DA-1:0]     dmem_addr_reg;
    logic [WORD_W-1:0] imem_wdata_reg, dmem_wdata_reg;
    logic              transfer;
    logic              imem_full, dmem_full;

    assign bus.in_ready     = (state_reg == S_LOAD_I) || (state_reg == S_LOAD_D);
    assign transfer         = bus.in_valid && bus.in_ready;
    assign imem_full        = (instr_count_reg == I_FULL);
    assign dmem_full        = (data_count_reg == D_FULL);

    assign bus.start_signal = (state_reg == S_RUN);
    assign done             = (state_reg == S_DONE);
    assign instr_count      = instr_count_reg;
    assign data_count       = data_count_reg;
    assign overflow_err     = overflow_reg;

    assign bus.imem_we      = imem_we_reg;
    assign bus.imem_addr    = imem_addr_reg;
    assign bus.imem_wdata   = imem_wdata_reg;
    assign bus.dmem_we      = dmem_we_reg;
    assign bus.dmem_addr    = dmem_addr_reg;
    assign bus.dmem_wdata   = dmem_wdata_reg;

    // in_last advances the segment even when the word itself is dropped as overflow.
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            S_LOAD_I: if (transfer && bus.in_last) state_next = S_LOAD_D;
            S_LOAD_D: if (transfer && bus.in_last) state_next = S_RUN;
            S_RUN:    if (bus.end_signal)          state_next = S_DONE;
            default:  state_next = S_DONE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg       <= S_LOAD_I;
            instr_count_reg <= '0;
            data_count_reg  <= '0;
            overflow_reg    <= 1'b0;
            imem_we_reg     <= 1'b0;
            dmem_we_reg     <= 1'b0;
            imem_addr_reg   <= '0;
            dmem_addr_reg   <= '0;
            imem_wdata_reg  <= '0;
            dmem_wdata_reg  <= '0;
        end else begin
            state_reg   <= state_next;
            imem_we_reg <= 1'b0;
            dmem_we_reg <= 1'b0;
            // The write address is the pre-increment count, so words land at 0,1,2...
            if (transfer && state_reg == S_LOAD_I) begin
                if (imem_full) begin
                    overflow_reg <= 1'b1;
                end else begin
                    imem_we_reg     <= 1'b1;
                    imem_addr_reg   <= instr_count_reg[IA-1:0];
                    imem_wdata_reg  <= bus.in_word;
                    instr_count_reg <= instr_count_reg + 1'b1;
                end
            end
            if (transfer && state_reg == S_LOAD_D) begin
                if (dmem_full) begin
                    overflow_reg <= 1'b1;
                end else begin
                    dmem_we_reg    <= 1'b1;
                    dmem_addr_reg  <= data_count_reg[DA-1:0];
                    dmem_wdata_reg <= bus.in_word;
                    data_count_reg <= data_count_reg + 1'b1;
                end
            end
        end
    end
endmodule
